load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage controller sitting directly upstream of the word-wide data memory. Accepts one load/store per handshake.
//  Drives word address, write enable and write data. Extracts and sign/zero-extends byte/halfword loads.
//  Performs SB/SH as a two-cycle read-merge-write, because memory writes only whole words.
//  Stalls the pipeline through req_ready; flags misaligned accesses instead of touching memory.
// PARAMETERS
//  LITTLE_ENDIAN  1  1: byte lane = addr[1:0]; 0: byte lane = 3-addr[1:0] (halfword lane mirrored likewise)
// PORTS
//  system_clock      in   1   sole clock, rising edge
//  reset             in   1   asynchronous, active-high
//  req_valid         in   1   request present
//  req_ready         out  1   high only in IDLE; accept = req_valid & req_ready
//  req_op            in   3   000 LB,001 LH,010 LW,011 SW,100 LBU,101 LHU,110 SB,111 SH
//  req_address       in   32  byte address
//  req_store_data    in   32  store operand, low bits used for SB/SH
//  load_valid        out  1   one-cycle pulse, load_data valid
//  load_data         out  32  extended load result, held until next load
//  misaligned        out  1   one-cycle pulse, accepted request rejected
//  mem_write_enable  out  1   to memory write enable
//  mem_address       out  32  to memory address (registered copy of req_address)
//  mem_write_data    out  32  to memory write data
//  mem_read_data     in   32  from memory, combinational read of mem_address
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, load_valid=0, load_data=0, misaligned=0, mem_write_enable=0,
//   mem_address=0, mem_write_data=0. An in-flight SB/SH is abandoned: no write, memory unchanged.
//  On accept: op, address and store data are captured into registers. mem_address = captured address.
//  Misalignment check at accept: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0.
//   On misalignment: stay in IDLE; misaligned=1 the next cycle. No memory write, no load_valid.
//  FSM states: IDLE, ACCESS, MERGE_WRITE.
//   IDLE -> ACCESS on aligned accept; otherwise stay in IDLE.
//   ACCESS, loads: extract lane from mem_read_data and extend (LB/LH sign, LBU/LHU zero, LW unchanged).
//    Register the result into load_data and set load_valid=1 in the following cycle. -> IDLE.
//   ACCESS, SW: mem_write_enable=1, mem_write_data=store word. Write lands on this edge. -> IDLE.
//   ACCESS, SB/SH: latch mem_read_data into merge buffer with the target lane replaced by store byte/half.
//    mem_write_enable=0. -> MERGE_WRITE.
//   MERGE_WRITE: mem_write_enable=1, mem_write_data=merge buffer. -> IDLE.
//  mem_write_enable is a pure decode of state/op registers; it is never high in IDLE.
//  Latency from accept edge: load result 2 cycles; SW committed 1 cycle; SB/SH committed 2 cycles.
//  req_ready is low in ACCESS and MERGE_WRITE.
//  Back-to-back: ready reasserts in the cycle load_valid pulses; a new accept may coincide with that pulse.
//  req_valid while not ready is ignored; inputs need not be held stable.
//  Address bits [31:2] pass through unchanged; wrap-around is the memory's responsibility.
// STRUCTURE
//  Shared header mem_ops.vh (`ifndef guarded): op encodings, FSM state encodings, op-class helpers.
//  Helper functions: is_store, is_sub_word, access size.
//  Sub-module byte_lane_align (combinational, LITTLE_ENDIAN param): load extract/extend and store merge.
//   Instantiated once for extract and once for merge; FSM and registers stay in load_store_unit.
// TESTING
//  Preload word[0]=0x8899AABB (LE). LB @0x3 -> load_valid 2 cycles after accept, load_data=0xFFFFFF88.
//   LBU @0x3 -> 0x00000088.
//  SB 0x12 @0x1 over 0x8899AABB -> req_ready low 2 cycles, one write pulse. LW @0x0 then returns 0x889912BB.
//  SH 0x5566 @0x2 over 0x8899AABB -> 0x5566AABB. LH @0x2 -> 0x00005566.
//   With LITTLE_ENDIAN=0, LH @0x2 -> 0xFFFFAABB.
//  LW @0x6 and SH @0x5 -> misaligned pulse next cycle. mem_write_enable never high, memory unchanged, ready stays high.
//  Assert reset during MERGE_WRITE of SB 0xFF @0x0 -> outputs zero immediately, word[0] unchanged.
//  Back-to-back with req_valid held high: LW, SW, LW at 0x10. Second LW returns the new value.
//   No request dropped or duplicated.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - op encodings, FSM states and op-class helpers for load_store_unit
package load_store_unit_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LH  = 3'b001,
      OP_LW  = 3'b010,
      OP_SW  = 3'b011,
      OP_LBU = 3'b100,
      OP_LHU = 3'b101,
      OP_SB  = 3'b110,
      OP_SH  = 3'b111
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_ACCESS      = 2'd1,
      ST_MERGE_WRITE = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } access_size_e;

   function automatic access_size_e access_size(input mem_op_e op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
         OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
         default:              return SIZE_WORD;
      endcase
   endfunction

   function automatic logic is_store(input mem_op_e op);
      return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
   endfunction

   function automatic logic is_sub_word(input mem_op_e op);
      return access_size(op) != SIZE_WORD;
   endfunction

   function automatic logic is_signed_load(input mem_op_e op);
      return (op == OP_LB) || (op == OP_LH);
   endfunction

   function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
      case (access_size(op))
         SIZE_HALF: return addr_lo[0];
         SIZE_WORD: return addr_lo != 2'b00;
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/byte_lane_align.sv
// rtl/byte_lane_align.sv - combinational lane select: load extract/extend (MERGE=0) or store merge (MERGE=1)
module byte_lane_align
   import load_store_unit_pkg::*;
#(
   parameter bit LITTLE_ENDIAN = 1'b1,
   parameter bit MERGE         = 1'b0
)
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] data_o
);

   logic [1:0]  byte_lane;
   logic        half_lane;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] extracted;
   logic [31:0] merged;

   // Big-endian mirrors both the byte index and the halfword index within the word.
   assign byte_lane = LITTLE_ENDIAN ? addr_lo_i : (2'd3 - addr_lo_i);
   assign half_lane = LITTLE_ENDIAN ? addr_lo_i[1] : ~addr_lo_i[1];
   assign lane_byte = word_i[8*byte_lane +: 8];
   assign lane_half = word_i[16*half_lane +: 16];

   always_comb begin
      extracted = word_i;
      merged    = store_data_i;
      case (size_i)
         SIZE_BYTE: begin
            extracted = {{24{sign_i & lane_byte[7]}}, lane_byte};
            merged    = word_i;
            merged[8*byte_lane +: 8] = store_data_i[7:0];
         end
         SIZE_HALF: begin
            extracted = {{16{sign_i & lane_half[15]}}, lane_half};
            merged    = word_i;
            merged[16*half_lane +: 16] = store_data_i[15:0];
         end
         default: begin
            extracted = word_i;
            merged    = store_data_i;
         end
      endcase
   end

   assign data_o = MERGE ? merged : extracted;

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store controller in front of a word-wide data memory;
// sub-word stores are done as read-merge-write.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter bit LITTLE_ENDIAN = 1'b1
)
(
   input  logic        system_clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_address,
   input  logic [31:0] req_store_data,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        mem_write_enable,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   lsu_state_e  state_q;
   mem_op_e     op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] load_data_q;
   logic        load_valid_q;
   logic        misaligned_q;
   logic [31:0] extracted;
   logic [31:0] merged;
   mem_op_e     req_op_e;
   logic        accept;

   assign req_op_e  = mem_op_e'(req_op);
   assign req_ready = (state_q == ST_IDLE);
   assign accept    = req_valid & req_ready;

   byte_lane_align #(.LITTLE_ENDIAN(LITTLE_ENDIAN), .MERGE(1'b0)) u_extract (
      .word_i       (mem_read_data),
      .addr_lo_i    (addr_q[1:0]),
      .size_i       (access_size(op_q)),
      .sign_i       (is_signed_load(op_q)),
      .store_data_i (wdata_q),
      .data_o       (extracted)
   );

   byte_lane_align #(.LITTLE_ENDIAN(LITTLE_ENDIAN), .MERGE(1'b1)) u_merge (
      .word_i       (mem_read_data),
      .addr_lo_i    (addr_q[1:0]),
      .size_i       (access_size(op_q)),
      .sign_i       (is_signed_load(op_q)),
      .store_data_i (wdata_q),
      .data_o       (merged)
   );

   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_LB;
         addr_q       <= '0;
         wdata_q      <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         misaligned_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q    <= req_op_e;
                  addr_q  <= req_address;
                  wdata_q <= req_store_data;
                  if (is_misaligned(req_op_e, req_address[1:0])) begin
                     misaligned_q <= 1'b1;
                  end else begin
                     state_q <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (!is_store(op_q)) begin
                  load_data_q  <= extracted;
                  load_valid_q <= 1'b1;
                  state_q      <= ST_IDLE;
               end else if (is_sub_word(op_q)) begin
                  // Old word with the target lane replaced becomes the write data.
                  wdata_q <= merged;
                  state_q <= ST_MERGE_WRITE;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_MERGE_WRITE: state_q <= ST_IDLE;
            default:        state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_write_enable = ((state_q == ST_ACCESS) && (op_q == OP_SW)) ||
                             (state_q == ST_MERGE_WRITE);
   assign mem_address      = addr_q;
   assign mem_write_data   = wdata_q;
   assign load_data        = load_data_q;
   assign load_valid       = load_valid_q;
   assign misaligned       = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit, little- and big-endian instances
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  req_op;
   logic [31:0] req_address, req_store_data;
   logic        valid_le, valid_be;
   logic        ready_le, ready_be, lv_le, lv_be, mis_le, mis_be, we_le, we_be;
   logic [31:0] ld_le, ld_be, addr_le, addr_be, wd_le, wd_be, rd_le, rd_be;
   logic [31:0] mem_le [0:15];
   logic [31:0] mem_be [0:15];
   logic        tb_we;
   logic [3:0]  tb_idx;
   logic [31:0] tb_wdata;
   int cyc = 0;
   int wr_count = 0;
   int checks = 0;
   int errors = 0;

   int          exp_unit[$];
   int          exp_kind[$];
   logic [31:0] exp_data[$];
   int          exp_cyc[$];
   string       exp_name[$];

   load_store_unit #(.LITTLE_ENDIAN(1'b1)) dut_le (
      .system_clock(clk), .reset(reset), .req_valid(valid_le), .req_ready(ready_le),
      .req_op(req_op), .req_address(req_address), .req_store_data(req_store_data),
      .load_valid(lv_le), .load_data(ld_le), .misaligned(mis_le),
      .mem_write_enable(we_le), .mem_address(addr_le), .mem_write_data(wd_le),
      .mem_read_data(rd_le)
   );

   load_store_unit #(.LITTLE_ENDIAN(1'b0)) dut_be (
      .system_clock(clk), .reset(reset), .req_valid(valid_be), .req_ready(ready_be),
      .req_op(req_op), .req_address(req_address), .req_store_data(req_store_data),
      .load_valid(lv_be), .load_data(ld_be), .misaligned(mis_be),
      .mem_write_enable(we_be), .mem_address(addr_be), .mem_write_data(wd_be),
      .mem_read_data(rd_be)
   );

   assign rd_le = mem_le[addr_le[5:2]];
   assign rd_be = mem_be[addr_be[5:2]];

   always @(posedge clk) begin
      if (tb_we) begin
         mem_le[tb_idx] <= tb_wdata;
         mem_be[tb_idx] <= tb_wdata;
      end else begin
         if (we_le) mem_le[addr_le[5:2]] <= wd_le;
         if (we_be) mem_be[addr_be[5:2]] <= wd_be;
      end
      if (we_le | we_be) wr_count <= wr_count + 1;
      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pop_check(input int unit, input int kind, input logic [31:0] data);
      string nm;
      if (exp_kind.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_output: unit %0d kind %0d data %h, scoreboard empty", unit, kind, data);
      end else begin
         nm = exp_name.pop_front();
         check({nm, "_unit"}, unit, exp_unit.pop_front());
         check({nm, "_kind"}, kind, exp_kind.pop_front());
         check({nm, "_data"}, data, exp_data.pop_front());
         check({nm, "_cycle"}, cyc, exp_cyc.pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (lv_le)  pop_check(0, 0, ld_le);
         if (mis_le) pop_check(0, 1, 32'd0);
         if (lv_be)  pop_check(1, 0, ld_be);
         if (mis_be) pop_check(1, 1, 32'd0);
      end
   end

   // kind: 0 load (expect data two cycles on), 1 misaligned pulse next cycle, 2 store (no response)
   task automatic issue(input int unit, input mem_op_e op, input logic [31:0] addr,
                        input logic [31:0] sdata, input int kind, input logic [31:0] exp,
                        input string name, output int waited);
      req_op         = op;
      req_address    = addr;
      req_store_data = sdata;
      valid_le       = (unit == 0);
      valid_be       = (unit == 1);
      waited         = 0;
      while (!((unit == 0) ? ready_le : ready_be) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 20) begin
         checks++;
         errors++;
         $display("FAIL %s_ready_timeout: got ready low for %0d cycles expected accept", name, waited);
      end else if (kind != 2) begin
         exp_unit.push_back(unit);
         exp_kind.push_back(kind);
         exp_data.push_back(kind == 0 ? exp : 32'd0);
         exp_cyc.push_back(kind == 0 ? cyc + 2 : cyc + 1);
         exp_name.push_back(name);
      end
      @(negedge clk);
   endtask

   task automatic stop_req();
      valid_le = 1'b0;
      valid_be = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_kind.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, exp_kind.size(), 32'd0);
      exp_unit.delete(); exp_kind.delete(); exp_data.delete(); exp_cyc.delete(); exp_name.delete();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int w;
      int wr0;
      reset = 1'b1;
      valid_le = 1'b0; valid_be = 1'b0;
      req_op = 3'd0; req_address = '0; req_store_data = '0;
      tb_we = 1'b0; tb_idx = '0; tb_wdata = '0;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         tb_we  = 1'b1;
         tb_idx = 4'(i);
         case (i)
            0:       tb_wdata = 32'h8899AABB;
            1:       tb_wdata = 32'h11223344;
            4:       tb_wdata = 32'h01020304;
            default: tb_wdata = 32'h0;
         endcase
      end
      @(negedge clk);
      tb_we = 1'b0;

      check("rst_ready", ready_le, 1);
      check("rst_load_valid", lv_le, 0);
      check("rst_load_data", ld_le, 0);
      check("rst_misaligned", mis_le, 0);
      check("rst_we", we_le, 0);
      check("rst_address", addr_le, 0);
      check("rst_wdata", wd_le, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      wr0 = wr_count;
      issue(0, OP_LB,  32'h3, 32'h0,  0, 32'hFFFFFF88, "lb_3", w);
      issue(0, OP_LBU, 32'h3, 32'h0,  0, 32'h00000088, "lbu_3", w);
      issue(0, OP_SB,  32'h1, 32'h12, 2, 32'h0, "sb_1", w);
      issue(0, OP_LW,  32'h0, 32'h0,  0, 32'h889912BB, "lw_after_sb", w);
      check("sb_ready_low_cycles", w, 2);
      stop_req();
      drain("sb_phase");
      check("sb_write_pulses", wr_count - wr0, 1);

      issue(0, OP_SW,  32'h0, 32'h8899AABB, 2, 32'h0, "sw_restore", w);
      issue(0, OP_SH,  32'h2, 32'h5566, 2, 32'h0, "sh_2", w);
      issue(0, OP_LH,  32'h2, 32'h0, 0, 32'h00005566, "lh_2", w);
      check("sh_ready_low_cycles", w, 2);
      issue(0, OP_LW,  32'h0, 32'h0, 0, 32'h5566AABB, "lw_after_sh", w);
      issue(0, OP_LH,  32'h0, 32'h0, 0, 32'hFFFFAABB, "lh_0", w);
      issue(0, OP_LHU, 32'h0, 32'h0, 0, 32'h0000AABB, "lhu_0", w);
      issue(0, OP_LB,  32'h1, 32'h0, 0, 32'hFFFFFFAA, "lb_1", w);
      stop_req();
      drain("half_phase");

      wr0 = wr_count;
      issue(0, OP_LW,  32'h6, 32'h0, 1, 32'h0, "mis_lw_6", w);
      issue(0, OP_SH,  32'h5, 32'hBEEF, 1, 32'h0, "mis_sh_5", w);
      check("mis_ready_stays_high", w, 0);
      issue(0, OP_LW,  32'h4, 32'h0, 0, 32'h11223344, "lw_after_mis", w);
      check("mis_ready_after_sh", w, 0);
      stop_req();
      drain("mis_phase");
      check("mis_no_writes", wr_count - wr0, 0);

      wr0 = wr_count;
      issue(0, OP_LW,  32'h10, 32'h0, 0, 32'h01020304, "b2b_lw_old", w);
      issue(0, OP_SW,  32'h10, 32'hCAFEF00D, 2, 32'h0, "b2b_sw", w);
      check("b2b_sw_wait", w, 1);
      issue(0, OP_LW,  32'h10, 32'h0, 0, 32'hCAFEF00D, "b2b_lw_new", w);
      check("b2b_lw_wait", w, 1);
      stop_req();
      drain("b2b_phase");
      check("b2b_write_pulses", wr_count - wr0, 1);

      wr0 = wr_count;
      issue(0, OP_SB, 32'h0, 32'hFF, 2, 32'h0, "sb_reset", w);
      stop_req();
      @(posedge clk);
      #1;
      check("merge_write_active", we_le, 1);
      reset = 1'b1;
      #1;
      check("async_rst_we", we_le, 0);
      check("async_rst_address", addr_le, 0);
      check("async_rst_wdata", wd_le, 0);
      check("async_rst_load_data", ld_le, 0);
      check("async_rst_ready", ready_le, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_word0_unchanged", mem_le[0], 32'h5566AABB);
      check("rst_no_write", wr_count - wr0, 0);
      check("word1_unchanged", mem_le[1], 32'h11223344);
      check("word4_final", mem_le[4], 32'hCAFEF00D);

      issue(1, OP_LH,  32'h2, 32'h0,  0, 32'hFFFFAABB, "be_lh_2", w);
      issue(1, OP_LBU, 32'h0, 32'h0,  0, 32'h00000088, "be_lbu_0", w);
      issue(1, OP_SB,  32'h0, 32'h12, 2, 32'h0, "be_sb_0", w);
      issue(1, OP_LW,  32'h0, 32'h0,  0, 32'h1299AABB, "be_lw_0", w);
      stop_req();
      drain("be_phase");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
